burst_addr_gen: RTL

Parametrised burst address generator.
- Accepts one burst command (start address, length, mode) over a valid/ready handshake.
- Emits one address per beat over a second valid/ready handshake, flagging the last beat.
- Supports FIXED, INCR and WRAP modes, with backpressure.
- Sits between the command decoder and the memory/bus interface for burst transactions.

---
 rtl/burst_addr_gen.sv | 137 +++++++++++++
 1 files changed

// File: rtl/burst_addr_gen.sv
// Burst address generator: takes one burst command (start, length, mode)
// and emits one address per beat, with FIXED, INCR and WRAP sequencing,
// consumer backpressure and a one-cycle error pulse for illegal commands.
module burst_addr_gen #(
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [1:0]            cmd_mode,
    output logic                  addr_valid,
    input  logic                  addr_ready,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic                  addr_last,
    output logic [LEN_WIDTH-1:0]  beat_idx,
    output logic                  busy,
    output logic                  err
);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    typedef enum logic [1:0] {
        MODE_FIXED = 2'b00,
        MODE_INCR  = 2'b01,
        MODE_WRAP  = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_t;

    state_t                state;
    state_t                state_nxt;
    mode_t                 mode_r;
    logic [LEN_WIDTH-1:0]  len_r;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [ADDR_WIDTH-1:0] addr_inc;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic                  cmd_accept;
    logic                  cmd_legal;
    logic                  len_pow2;
    logic                  beat_done;

    // A WRAP burst needs len+1 to be a power of two of at least 2; with
    // len+1 a power of two, len itself is the in-window offset mask.
    assign len_pow2   = ((cmd_len & LEN_WIDTH'(cmd_len + 1'b1)) == '0);
    assign cmd_legal  = (mode_t'(cmd_mode) != MODE_RSVD) &&
                        !((mode_t'(cmd_mode) == MODE_WRAP) && ((cmd_len == '0) || !len_pow2));
    assign cmd_accept = cmd_valid && (state == IDLE);
    assign beat_done  = addr_valid && addr_ready;

    // Next beat address: INCR rolls over the full address space, WRAP stays
    // inside the len+1 aligned window that holds the start address.
    assign wrap_mask = ADDR_WIDTH'(len_r);
    assign addr_inc  = addr_out + 1'b1;
    always_comb begin
        addr_nxt = addr_out;
        case (mode_r)
            MODE_INCR: addr_nxt = addr_inc;
            MODE_WRAP: addr_nxt = (addr_out & ~wrap_mask) | (addr_inc & wrap_mask);
            default:   addr_nxt = addr_out;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block ordering.
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs decoded from the current state.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value
        // unassigned, which would otherwise infer a latch.
        state_nxt  = state;
        cmd_ready  = 1'b0;
        addr_valid = 1'b0;
        busy       = 1'b0;
        addr_last  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid && cmd_legal) begin
                    state_nxt = BURST;
                end
            end
            BURST: begin
                addr_valid = 1'b1;
                busy       = 1'b1;
                addr_last  = (beat_idx == len_r);
                if (addr_ready && addr_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Command capture, beat sequencing and error pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: len_r and mode_r are reset too, although only read in
            // BURST, so the block has no X state after reset anywhere.
            addr_out <= '0;
            beat_idx <= '0;
            len_r    <= '0;
            mode_r   <= MODE_FIXED;
            err      <= 1'b0;
        end else begin
            err <= cmd_accept && !cmd_legal;
            if (cmd_accept && cmd_legal) begin
                addr_out <= cmd_addr;
                beat_idx <= '0;
                len_r    <= cmd_len;
                mode_r   <= mode_t'(cmd_mode);
            end else if (beat_done) begin
                if (addr_last) begin
                    // addr_out keeps the final beat address once idle.
                    beat_idx <= '0;
                end else begin
                    beat_idx <= beat_idx + 1'b1;
                    addr_out <= addr_nxt;
                end
            end
        end
    end

endmodule
